// File: rtl/even_parity_tx_if.sv
// Handshake and serial-stream bundle for the even-parity frame transmitter.
// master is the word source / stream sink side; slave is the transmitter.
interface even_parity_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             w;
    logic             w_valid;
    logic             last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  w,
        input  w_valid,
        input  last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output w,
        output w_valid,
        output last
    );
endinterface

// File: rtl/even_parity_tx.sv
// Serial parity frame transmitter: WIDTH data bits LSB first, then one parity bit.
// All outputs are registered; a word offered during the parity cycle follows with no gap.
module even_parity_tx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                pos,
    input  logic                rst,
    even_parity_tx_if.slave     bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             accept;

    assign accept = bus.in_valid & bus.in_ready;

    // w always holds the bit of index cnt; shift holds the bits not yet shown,
    // and acc already includes the bit currently on w.
    always_ff @(posedge pos or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shift        <= '0;
            cnt          <= '0;
            acc          <= 1'b0;
            bus.w        <= 1'b0;
            bus.w_valid  <= 1'b0;
            bus.last     <= 1'b0;
            bus.in_ready <= 1'b1;
        end else begin
            case (state)
                DATA: begin
                    if (cnt == LAST_IDX) begin
                        state        <= PAR;
                        bus.w        <= acc ^ PARITY_ODD;
                        bus.last     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end else begin
                        bus.w <= shift[0];
                        acc   <= acc ^ shift[0];
                        shift <= shift >> 1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and PAR share the accept path, giving gap-free back-to-back frames
                    if (accept) begin
                        state        <= DATA;
                        shift        <= bus.in_data >> 1;
                        cnt          <= '0;
                        acc          <= bus.in_data[0];
                        bus.w        <= bus.in_data[0];
                        bus.w_valid  <= 1'b1;
                        bus.last     <= 1'b0;
                        bus.in_ready <= 1'b0;
                    end else begin
                        state        <= IDLE;
                        bus.w        <= 1'b0;
                        bus.w_valid  <= 1'b0;
                        bus.last     <= 1'b0;
                        bus.in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_even_parity_tx.sv
// Bench for even_parity_tx: four instances (W8 even, W8 odd, W1, W32) against a frame-queue model.
module tb_even_parity_tx;
    logic pos = 1'b0;
    logic rst = 1'b1;
    always #5 pos = ~pos;

    localparam int WID [4] = '{8, 8, 1, 32};
    localparam bit ODD [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    even_parity_tx_if #(.WIDTH(8))  b0 ();
    even_parity_tx_if #(.WIDTH(8))  b1 ();
    even_parity_tx_if #(.WIDTH(1))  b2 ();
    even_parity_tx_if #(.WIDTH(32)) b3 ();

    even_parity_tx #(.WIDTH(8),  .PARITY_ODD(1'b0)) u0 (.pos(pos), .rst(rst), .bus(b0));
    even_parity_tx #(.WIDTH(8),  .PARITY_ODD(1'b1)) u1 (.pos(pos), .rst(rst), .bus(b1));
    even_parity_tx #(.WIDTH(1),  .PARITY_ODD(1'b0)) u2 (.pos(pos), .rst(rst), .bus(b2));
    even_parity_tx #(.WIDTH(32), .PARITY_ODD(1'b0)) u3 (.pos(pos), .rst(rst), .bus(b3));

    logic [31:0] i_data [4];
    logic [3:0]  i_vld;
    logic [3:0]  o_w, o_wv, o_last, o_rdy;

    assign b0.in_data  = i_data[0][7:0];
    assign b1.in_data  = i_data[1][7:0];
    assign b2.in_data  = i_data[2][0:0];
    assign b3.in_data  = i_data[3];
    assign b0.in_valid = i_vld[0];
    assign b1.in_valid = i_vld[1];
    assign b2.in_valid = i_vld[2];
    assign b3.in_valid = i_vld[3];
    assign o_w    = {b3.w,        b2.w,        b1.w,        b0.w};
    assign o_wv   = {b3.w_valid,  b2.w_valid,  b1.w_valid,  b0.w_valid};
    assign o_last = {b3.last,     b2.last,     b1.last,     b0.last};
    assign o_rdy  = {b3.in_ready, b2.in_ready, b1.in_ready, b0.in_ready};

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame the spec describes: data bits then the bit that fixes the ones-count parity.
    function automatic logic [63:0] model_frame(int i, logic [31:0] d);
        logic [63:0] m;
        logic [63:0] v;
        logic        p;
        m = (64'd1 << WID[i]) - 64'd1;
        v = {32'd0, d} & m;
        p = (($countones(v) % 2) == 1) ^ ODD[i];
        return v | ({63'd0, p} << WID[i]);
    endfunction

    // Model: per instance, the bits still to appear on w (front = current) and how many remain.
    logic [63:0] frm [4];
    int          rem [4] = '{0, 0, 0, 0};
    logic        take_m;

    always begin
        @(posedge pos);
        for (int i = 0; i < 4; i++) begin
            if (!rst) begin
                rem[i] = 0;
                frm[i] = '0;
            end else begin
                take_m = i_vld[i] && (rem[i] <= 1);
                if (rem[i] > 0) begin
                    frm[i] = frm[i] >> 1;
                    rem[i]--;
                end
                if (take_m) begin
                    frm[i] = model_frame(i, i_data[i]);
                    rem[i] = WID[i] + 1;
                end
            end
        end
        @(negedge pos);
        for (int i = 0; i < 4; i++) begin
            if (!rst) begin
                rem[i] = 0;
                frm[i] = '0;
            end
            chk($sformatf("cyc_u%0d{wv,w,last,rdy}", i),
                {60'd0, o_wv[i], o_w[i], o_last[i], o_rdy[i]},
                {60'd0, rem[i] > 0, (rem[i] > 0) && frm[i][0], rem[i] == 1, rem[i] <= 1});
        end
    end

    task automatic send(int i, logic [31:0] d);
        int n;
        n = 0;
        i_data[i] = d;
        i_vld[i]  = 1'b1;
        while (o_rdy[i] !== 1'b1 && n < 200) begin
            @(negedge pos);
            n++;
        end
        if (n >= 200) begin
            n_bad++;
            $display("FAIL send_timeout u%0d: in_ready never 1 after %0d cycles", i, n);
        end
        @(posedge pos);
        #1;
        i_vld[i] = 1'b0;
    endtask

    task automatic capture(int i, output logic [32:0] cw, output logic [32:0] cl, output int nv);
        cw = '0;
        cl = '0;
        nv = 0;
        for (int k = 0; k <= WID[i]; k++) begin
            @(negedge pos);
            cw[k] = o_w[i];
            cl[k] = o_last[i];
            if (o_wv[i]) nv++;
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic [32:0] exp_w;
        logic [32:0] exp_last;
        logic        exp_chk;
    } vec_t;

    vec_t        vt [8];
    logic [32:0] cw, cl;
    int          nv;
    int          nwv, nrdy, np, nacc;
    logic [2:0]  pbits;
    logic        seen_rdy;
    logic [31:0] d32;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 32'h00, 33'h000, 33'h100, 1'b0};
        vt[1] = '{0, 32'h01, 33'h101, 33'h100, 1'b0};
        vt[2] = '{0, 32'hFF, 33'h0FF, 33'h100, 1'b0};
        vt[3] = '{0, 32'hA7, 33'h1A7, 33'h100, 1'b0};
        vt[4] = '{1, 32'hA7, 33'h0A7, 33'h100, 1'b1};
        vt[5] = '{2, 32'h01, 33'h003, 33'h002, 1'b0};
        vt[6] = '{2, 32'h00, 33'h000, 33'h002, 1'b0};
        vt[7] = '{0, 32'h3C, 33'h03C, 33'h100, 1'b0};

        for (int i = 0; i < 4; i++) i_data[i] = '0;
        i_vld = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge pos);
        #1;
        chk("reset_values", {o_wv[0], o_w[0], o_last[0], o_rdy[0]}, 4'b0001);
        #2 rst = 1'b1;

        // Table of single frames across instances
        for (int j = 0; j < 8; j++) begin
            send(vt[j].inst, vt[j].data);
            capture(vt[j].inst, cw, cl, nv);
            chk($sformatf("vec%0d_w", j), cw, vt[j].exp_w);
            chk($sformatf("vec%0d_last", j), cl, vt[j].exp_last);
            chk($sformatf("vec%0d_nvalid", j), nv, WID[vt[j].inst] + 1);
            chk($sformatf("vec%0d_checker", j), ^cw, vt[j].exp_chk);
        end
        repeat (3) @(posedge pos);
        #1;

        // Back-to-back words held valid
        i_data[0] = 32'h3C;
        i_vld[0]  = 1'b1;
        @(posedge pos);
        #1;
        i_data[0] = 32'h81;
        nwv = 0; nrdy = 0; np = 0; nacc = 0; pbits = '0;
        for (int c = 0; c < 27; c++) begin
            @(negedge pos);
            if (o_wv[0]) nwv++;
            if (o_rdy[0]) nrdy++;
            if (o_last[0] && np < 3) begin
                pbits[np] = o_w[0];
                np++;
            end
            seen_rdy = o_rdy[0];
            @(posedge pos);
            #1;
            if (seen_rdy) begin
                nacc++;
                if (nacc == 1) i_data[0] = 32'h7F;
                if (nacc == 2) i_vld[0] = 1'b0;
            end
        end
        chk("b2b_valid_cycles", nwv, 27);
        chk("b2b_ready_cycles", nrdy, 3);
        chk("b2b_parity_bits", pbits, 3'b100);
        repeat (3) @(posedge pos);
        #1;

        // Stall: noise on in_data/in_valid during DATA, then a held word taken at PAR
        send(0, 32'h5A);
        cw = '0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge pos);
            cw[k] = o_w[0];
            if (k >= 1 && k <= 6) begin
                i_data[0] = $urandom;
                i_vld[0]  = k[0];
            end else if (k == 7) begin
                i_data[0] = 32'hC3;
                i_vld[0]  = 1'b1;
            end
        end
        chk("stall_frame_w", cw, 33'h05A);
        @(posedge pos);
        #1;
        i_vld[0] = 1'b0;
        capture(0, cw, cl, nv);
        chk("stall_held_word_w", cw, 33'h0C3);
        chk("stall_held_word_nvalid", nv, 9);
        repeat (3) @(posedge pos);
        #1;

        // Asynchronous reset mid-frame
        send(0, 32'hA7);
        repeat (4) @(negedge pos);
        @(posedge pos);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs", {o_wv[0], o_w[0], o_last[0], o_rdy[0]}, 4'b0001);
        repeat (2) @(posedge pos);
        #2 rst = 1'b1;
        nwv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge pos);
            if (o_wv[0]) nwv++;
        end
        chk("rst_no_parity_after", nwv, 0);
        #1;
        send(0, 32'h01);
        capture(0, cw, cl, nv);
        chk("post_rst_w", cw, 33'h101);
        chk("post_rst_last", cl, 33'h100);

        // WIDTH=32 random words
        for (int j = 0; j < 5; j++) begin
            d32 = $urandom;
            send(3, d32);
            capture(3, cw, cl, nv);
            chk($sformatf("w32_%0d_frame", j), cw, {^d32, d32});
            chk($sformatf("w32_%0d_last", j), cl, 33'h1_0000_0000);
        end
        repeat (3) @(posedge pos);
        #1;

        // Random traffic on every instance, checked cycle by cycle by the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                i_vld[i]  = ($urandom_range(0, 3) != 0);
                i_data[i] = $urandom;
            end
            @(posedge pos);
            #1;
        end
        i_vld = '0;
        repeat (40) @(posedge pos);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
